// File: rtl/farm_sensor_conditioner.sv
// farm_sensor_conditioner
// Front-end for the traffic light controller's farm road. It synchronises and
// debounces the vehicle loop sensor, counts the vehicles waiting, retires them
// while the farm green is lit, and raises a request and an urgency flag.
//
// Timing at default parameters: a raw sensor edge that is first sampled at
// clock edge N changes the accepted level at edge N+5. The arrival strobe is
// registered on that same edge. The waiting count moves one edge later.
//
// There is no valid/ready handshake. The sensor is a free-running level input.
// farm_green is sampled on every rising clock edge as the lamp state.
module farm_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4,
    parameter int DEPART_CYCLES   = 3,
    parameter int MAX_WAIT        = 50
) (
    input  logic             clk,
    input  logic             reset,          // active-low, asynchronous
    input  logic             sensor_raw,
    input  logic             farm_green,
    output logic             farm_request,
    output logic             farm_urgent,
    output logic             arrival_pulse,
    output logic [CNT_W-1:0] waiting_count
);

    localparam int DCNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DT_W   = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
    localparam int WT_W   = $clog2(MAX_WAIT + 1);

    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DT_W-1:0]   DT_LAST   = DT_W'(DEPART_CYCLES - 1);
    localparam logic [WT_W-1:0]   WT_MAX    = WT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic              s1;
    logic              s2;
    logic              deb;
    logic [DCNT_W-1:0] dcnt;
    logic [DT_W-1:0]   dt;
    logic [WT_W-1:0]   wt;

    logic deb_flip;
    logic deb_rise;
    logic departure;

    // The accepted level flips on this edge. s2 has now disagreed with deb
    // for DEBOUNCE_CYCLES consecutive edges.
    assign deb_flip  = (s2 != deb) && (dcnt == DCNT_LAST);
    assign deb_rise  = deb_flip && !deb;
    // A vehicle leaves on the last cycle of each DEPART_CYCLES-long green slot.
    assign departure = farm_green && (waiting_count != '0) && (dt == DT_LAST);

    assign farm_request = (waiting_count != '0);
    assign farm_urgent  = (wt == WT_MAX);

    // Two-flop synchroniser for the asynchronous loop detector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sensor_raw;
            s2 <= s1;
        end
    end

    // Debounce. Any bounce back to the accepted level restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb  <= 1'b0;
            dcnt <= '0;
        end else if (s2 == deb) begin
            dcnt <= '0;
        end else if (dcnt == DCNT_LAST) begin
            deb  <= s2;
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    // One-cycle arrival strobe on an accepted rising level only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arrival_pulse <= 1'b0;
        end else begin
            arrival_pulse <= deb_rise;
        end
    end

    // Departure timer. It runs only while green is lit and vehicles remain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dt <= '0;
        end else if (!farm_green || (waiting_count == '0)) begin
            dt <= '0;
        end else if (dt == DT_LAST) begin
            dt <= '0;
        end else begin
            dt <= dt + 1'b1;
        end
    end

    // Waiting-vehicle count. It saturates high, and an arrival that would
    // overflow it is dropped. An arrival and a departure in the same cycle
    // cancel out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waiting_count <= '0;
        end else if (arrival_pulse && !departure) begin
            if (waiting_count != CNT_MAX) begin
                waiting_count <= waiting_count + 1'b1;
            end
        end else if (departure && !arrival_pulse) begin
            waiting_count <= waiting_count - 1'b1;
        end
    end

    // Wait timer. It counts unserved cycles and saturates at MAX_WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wt <= '0;
        end else if ((waiting_count == '0) || farm_green) begin
            wt <= '0;
        end else if (wt != WT_MAX) begin
            wt <= wt + 1'b1;
        end
    end

endmodule

// File: doc/farm_sensor_conditioner.md
Name: farm_sensor_conditioner

Overview:
- Upstream front-end for the traffic light controller.
- Conditions the raw farm-road vehicle loop sensor: synchronises it, debounces it, and counts vehicles waiting.
- Issues `farm_request` and `farm_urgent` to the controller.
- Consumes the controller's `farm_green` output to retire vehicles as they depart.

Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive synchronised cycles a sensor level must persist before it is accepted.
- CNT_W, default 4: width of the waiting-vehicle counter; saturates at 2^CNT_W-1.
- DEPART_CYCLES, default 3: farm_green cycles per departing vehicle.
- MAX_WAIT, default 50: unserved wait cycles before farm_urgent asserts.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted); deassertion is synchronous to clk at system level.
- sensor_raw  in  1  asynchronous vehicle loop detector, 1 = vehicle present.
- farm_green  in  1  farm green lamp state from the traffic light controller.
- farm_request  out  1  at least one vehicle waiting.
- farm_urgent  out  1  vehicles unserved for MAX_WAIT cycles.
- arrival_pulse  out  1  one-cycle strobe per accepted vehicle arrival.
- waiting_count  out  CNT_W  vehicles currently waiting.

Behaviour:
- Reset (reset=0): all registers clear immediately, without waiting for a clock edge, including synchroniser, debounce state/counter, departure timer and wait timer. All outputs read 0. A pending debounce is discarded.
- Synchroniser: two flops on sensor_raw; output s2.
- Debounce:
  - Accepted level `deb` and counter `dcnt`.
  - If s2==deb: dcnt<=0.
  - Else if dcnt==DEBOUNCE_CYCLES-1: deb<=s2 and dcnt<=0.
  - Else: dcnt<=dcnt+1.
  - Any bounce back to deb restarts the count.
- Timing: raw edge sampled at clock edge N → deb changes at edge N+5 (defaults).
- arrival_pulse: registered. High for exactly the one cycle after the edge where deb goes 0→1. No pulse on a 1→0 transition.
- Departure timer `dt`:
  - Cleared whenever farm_green=0 or waiting_count==0.
  - Otherwise increments each cycle.
  - When dt==DEPART_CYCLES-1 a departure event occurs and dt wraps to 0.
- waiting_count update, one edge after the corresponding arrival_pulse/departure cycle:
  - arrival only: +1, but held at 2^CNT_W-1 (the arrival is dropped).
  - departure only: -1; never goes below 0.
  - both in the same cycle: unchanged.
  - neither: unchanged.
- farm_request = (waiting_count != 0). Decoded from the registered count; no added latency.
- Wait timer `wt`:
  - Cleared when waiting_count==0 or farm_green=1.
  - Otherwise increments, saturating at MAX_WAIT.
- farm_urgent = (wt == MAX_WAIT).
  - Clears on the edge after farm_green rises or the count reaches 0.
- Sensor held high through reset release: counts as a fresh arrival once synchronised and debounced (edge N+5 after release).
- farm_green high while count==0: no effect.

Test Plan:
- Glitch rejection: sensor_raw=1 for 3 cycles then 0 → no arrival_pulse; waiting_count stays 0; farm_request=0.
- Clean arrival: sensor_raw rises before edge 1 and is held 10 cycles.
  - arrival_pulse high for one cycle after edge 6.
  - waiting_count=1 and farm_request=1 after edge 7.
  - No second pulse on release.
- Service: 3 accepted arrivals, then farm_green=1 for 9 cycles → waiting_count goes 3→2→1→0, one step every 3 cycles; farm_request drops after the final decrement.
- Simultaneous events: waiting_count=2, farm_green=1, arrival_pulse coincident with a departure cycle → waiting_count remains 2 on that edge.
- Saturation and urgency:
  - 17 debounced arrivals with farm_green=0 → waiting_count holds at 15.
  - farm_urgent=1 exactly 50 cycles after the count first became nonzero.
  - Setting farm_green=1 clears farm_urgent on the next edge.
- Reset mid-operation: waiting_count=5, farm_urgent=1, dcnt mid-count; drive reset=0 between clock edges → all outputs 0 immediately. After release with sensor_raw=0, outputs stay 0.
